// File: rtl/div_unit.sv
// Multi-cycle signed divider for the DIV instruction: restoring division on
// operand magnitudes, one quotient bit per cycle, then a sign-fix cycle.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             DivStop,
  output logic             DivZero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_shift, rem_sub, a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, b_zero, rem_ge;

  // Magnitudes are plain unsigned negation, so the most negative value maps to itself.
  assign a_mag  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag  = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign b_zero = (B == '0);

  // The remainder stays below the divisor (at most 2^(WIDTH-1)), so the shifted
  // value always fits in WIDTH bits.
  assign rem_shift = {rem[WIDTH-2:0], dividend[WIDTH-1]};
  assign rem_ge    = (rem_shift >= divisor);
  assign rem_sub   = rem_shift - divisor;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block is assigned a default first so
  // that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (DivCtrl && !b_zero) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      HI_out   <= '0;
      LO_out   <= '0;
      DivStop  <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      DivStop <= 1'b0;
      DivZero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (DivCtrl) begin
            if (b_zero) begin
              DivZero <= 1'b1;
            end else begin
              dividend <= a_mag;
              divisor  <= b_mag;
              sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r   <= A[WIDTH-1];
              rem      <= '0;
              cnt      <= '0;
            end
          end
        end
        CALC: begin
          rem      <= rem_ge ? rem_sub : rem_shift;
          dividend <= {dividend[WIDTH-2:0], rem_ge};
          cnt      <= cnt + 1'b1;
        end
        FIX: begin
          LO_out  <= sign_q ? (~dividend + 1'b1) : dividend;
          HI_out  <= sign_r ? (~rem + 1'b1) : rem;
          DivStop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle signed 32-bit divider that answers the control unit's DIV request. The control unit raises `DivCtrl` in the DIV execute state and waits for `DivStop` (normal completion) or `DivZero` (exception path). The quotient and remainder are held on `LO_out` and `HI_out` for the HI/LO register write. The divider uses a one-bit-per-cycle restoring algorithm on operand magnitudes, followed by a sign-fix step, and follows MIPS DIV semantics.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is required to work.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high; clock `clk`.
- `DivCtrl`, in, 1: start request. Sampled only in IDLE.
- `A`, in, WIDTH: dividend (register A output), two's complement.
- `B`, in, WIDTH: divisor (register B output), two's complement.
- `HI_out`, out, WIDTH: remainder of the last completed division.
- `LO_out`, out, WIDTH: quotient of the last completed division.
- `DivStop`, out, 1: one-cycle pulse; the result on `HI_out`/`LO_out` is valid.
- `DivZero`, out, 1: one-cycle pulse; the divisor was 0 and no division was performed.
- `busy`, out, 1: high in CALC and FIX.

## Operation
States: IDLE, CALC, FIX.
- **IDLE:**
  - If `DivCtrl`=1 and `B`=0: pulse `DivZero` next cycle, stay in IDLE, leave `HI_out`/`LO_out` unchanged.
  - If `DivCtrl`=1 and `B`≠0: latch |A| into the dividend shift register and |B| into the divisor register. Latch sign_q = A[31]^B[31] and sign_r = A[31]. Clear the remainder accumulator R and the counter. Go to CALC.
- **CALC**, one iteration per cycle:
  - R' = {R[WIDTH-2:0], dividend MSB}; shift the dividend left by 1.
  - If R' ≥ divisor (unsigned): R = R' − divisor and shift in quotient bit 1. Otherwise R = R' and shift in 0.
  - Counter increments; after WIDTH iterations go to FIX.
- **FIX:**
  - `LO_out` = sign_q ? −Q : Q.
  - `HI_out` = sign_r ? −R : R.
  - Both use WIDTH-bit two's-complement wrap.
  - Assert `DivStop` next cycle and go to IDLE.
- Arithmetic rules:
  - Magnitudes are computed as unsigned WIDTH bits, so |0x80000000| = 0x80000000.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no flag).
- `DivCtrl` is ignored while `busy`=1. `A` and `B` are ignored after the start edge; they may change freely.
- Back-to-back operation: `DivCtrl`=1 in the cycle `DivStop` is high is accepted, because the state is IDLE.
- The `overflow` flag is never produced by this block.

## Timing
- Start edge = the edge at which `DivCtrl` is sampled high in IDLE.
- Nonzero divisor:
  - `busy` high from start+1 through the FIX cycle.
  - Edges start+1 through start+32 perform the 32 iterations.
  - At edge start+33, results are registered and `DivStop` goes high.
  - `DivStop` is high for exactly one cycle; results are readable in that cycle and afterwards.
  - Total: 33 cycles from start edge to the `DivStop` rising edge.
- Zero divisor: `DivZero` high for exactly one cycle after the start edge; `busy` stays 0; `DivStop` is never asserted.
- `DivStop` and `DivZero` are never high together.
- Reset values: state=IDLE, `HI_out`=0, `LO_out`=0, `DivStop`=0, `DivZero`=0, `busy`=0, counter=0, R=0.
- Reset mid-CALC or mid-FIX:
  - Abort to IDLE at that edge with all reset values.
  - No `DivStop` or `DivZero` for the aborted operation.
  - `reset` overrides a simultaneous `DivCtrl`.
- Outputs hold their value until the next successful completion or reset.

## Test plan
- A=7, B=2, pulse `DivCtrl` -> `DivStop` 33 cycles after the start edge, LO=3, HI=1, `busy` high for 33 cycles.
- A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then A=7, B=-2 -> LO=0xFFFFFFFD, HI=1.
- A=5, B=0 -> `DivZero` for 1 cycle, no `DivStop`, `busy`=0, HI/LO keep the previous result.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then A=3, B=10 -> LO=0, HI=3.
- Start 100/7, then pulse `DivCtrl` with A=1, B=1 at cycle 10 -> ignored; result LO=14, HI=2 at cycle 33. `DivCtrl` held high in the `DivStop` cycle with A=9, B=3 -> second result LO=3, HI=0 exactly 33 cycles later.
- Start 100/7, assert `reset` at cycle 20 -> IDLE next edge, all outputs 0, no `DivStop`. A new start after reset completes normally.
